regfile_wb_scheduler: RTL
=========================

Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x64 register file (registerFile: RegWrite/RD/WriteData, written on negedge clk).
- Arbitrates that port between two writeback producers, the ALU and the load unit, using valid/ready handshakes and round-robin fairness.
- Keeps a per-register pending-write scoreboard and raises a stall to the decode stage on RAW/WAW hazards against in-flight writes.

Parameters:
- XLEN, 64, data width of the write port
- NREG, 32, number of architectural registers
- AW, 5, register index width (log2 NREG)
- CW, 16, width of the saturating conflict counter

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request granted this cycle
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  load request granted this cycle
- mem_rd  input  AW  load destination register
- mem_data  input  XLEN  load result
- issue_valid  input  1  decode wants to issue an instruction
- issue_rd  input  AW  destination of the issuing instruction (0 = no destination)
- rs1  input  AW  source 1 of the issuing instruction
- rs2  input  AW  source 2 of the issuing instruction
- stall  output  1  issue blocked by a hazard
- RegWrite  output  1  register-file write enable
- RD  output  AW  register-file write index
- WriteData  output  XLEN  register-file write data
- busy_vec  output  NREG  scoreboard pending-write bits, bit 0 always 0
- conflict_cnt  output  CW  cycles in which both producers requested

Behaviour:
- Reset (sync, posedge with reset=1) clears state. RegWrite=0, RD=0, WriteData=0, busy_vec=0, conflict_cnt=0, rr pointer = mem-first.
- Reset has priority over every other event. A write registered in the previous cycle is dropped, so RegWrite=0 in the cycle after reset.
- Arbitration is combinational from this cycle's valids:
  - Only one producer valid: that producer is granted.
  - Both valid: grant follows the rr pointer.
  - ready = grant. At most one ready is high per cycle. ready never depends on the other's ready.
- Transfer occurs on valid&ready.
  - rr pointer toggles to the non-granted side only on a transfer made while both were valid.
- Write pipeline:
  - A transfer in cycle N produces RegWrite=1, RD=rd, WriteData=data registered for cycle N+1. Latency is 1 cycle.
  - The register file captures the write on the negedge inside N+1.
  - With no transfer, RegWrite=0 and RD/WriteData hold their previous values.
- x0 writes: a transfer with rd=0 completes the handshake but RegWrite stays 0 in N+1. The scoreboard is not touched.
- Scoreboard:
  - Set: issue accepted (issue_valid & ~stall) with issue_rd!=0 sets busy[issue_rd] at posedge.
  - Clear: busy[RD] clears at the posedge ending the cycle in which RegWrite=1, i.e. after the register file holds the data.
  - Simultaneous set and clear of the same index: set wins.
  - busy[0] is hard-wired 0.
- stall (combinational) = issue_valid & (busy[rs1] | busy[rs2] | busy[issue_rd]), using the current busy_vec.
  - No bypass: a source whose write is landing this cycle still stalls for this cycle.
  - When stall=1 the issue is ignored and the scoreboard is unchanged.
- conflict_cnt increments on every cycle with alu_valid & mem_valid and saturates at 2^CW-1.
- Producers must hold valid/rd/data stable until ready. Behaviour when they do not is undefined but must never produce X on RegWrite.

Test Plan:
- Reset mid-write: mem transfer of rd=5 then reset=1 next edge -> RegWrite=0 after reset, busy_vec=0, conflict_cnt=0.
- Single ALU write: issue rd=3, then alu_valid rd=3 data=0xDEAD -> alu_ready=1 same cycle; next cycle RegWrite=1 RD=3 WriteData=0xDEAD; busy[3] clears one edge later; issue with rs1=3 stalls through the RegWrite cycle and is accepted the cycle after.
- Contention: both valid for 4 cycles (alu rd=1..4, mem rd=9..12, each producer holds its request until granted) -> grants alternate mem, alu, mem, alu; RD sequence 9,1,10,2; conflict_cnt=4.
- x0 drop: alu_valid rd=0 data=0xFFFF -> alu_ready=1, RegWrite stays 0, busy_vec unchanged.
- Set/clear collision: RegWrite=1 RD=7 in the same cycle as an accepted issue with issue_rd=7 -> busy[7]=1 after the edge.
- WAW stall: busy[8]=1, issue_rd=8 with rs1=rs2=0 -> stall=1; issue is not accepted until busy[8] clears.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x64 register file: round-robin arbitration of the
// ALU and load producers onto the single write port, plus a pending-write scoreboard.
module regfile_wb_scheduler #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            stall,
  output logic            RegWrite,
  output logic [AW-1:0]   RD,
  output logic [XLEN-1:0] WriteData,
  output logic [NREG-1:0] busy_vec,
  output logic [CW-1:0]   conflict_cnt
);

  // Handshake: a producer transfers in any cycle where its valid and ready are both
  // high; ready is a pure function of the two valids and the round-robin pointer.
  logic            mem_first_q, mem_first_d;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            both_valid;
  logic            xfer;
  logic [AW-1:0]   xfer_rd;
  logic [XLEN-1:0] xfer_data;
  logic            issue_ok;

  assign both_valid = alu_valid & mem_valid;
  assign alu_ready  = alu_valid & ~(mem_valid & mem_first_q);
  assign mem_ready  = mem_valid & ~(alu_valid & ~mem_first_q);
  assign xfer       = alu_ready | mem_ready;
  assign xfer_rd    = mem_ready ? mem_rd : alu_rd;
  assign xfer_data  = mem_ready ? mem_data : alu_data;

  // No bypass from the landing write: busy bits are only read from the register.
  assign stall    = issue_valid & (busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd]);
  assign issue_ok = issue_valid & ~stall;

  always_comb begin
    mem_first_d = mem_first_q;
    if (both_valid) begin
      mem_first_d = ~mem_ready;
    end

    regwrite_d = xfer & (xfer_rd != '0);
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (regwrite_d) begin
      rd_d    = xfer_rd;
      wdata_d = xfer_data;
    end

    // Clear first so that a same-index set in this cycle wins.
    busy_d = busy_q;
    if (regwrite_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_ok && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (both_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_first_q <= 1'b1;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      busy_q      <= '0;
      cnt_q       <= '0;
    end else begin
      mem_first_q <= mem_first_d;
      regwrite_q  <= regwrite_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign RegWrite     = regwrite_q;
  assign RD           = rd_q;
  assign WriteData    = wdata_q;
  assign busy_vec     = busy_q;
  assign conflict_cnt = cnt_q;

endmodule
